// File: rtl/period_meter.sv
// Measures the period of an asynchronous pulse train in clk cycles, with
// saturation at 255, an abandon-after-silence timeout and a synchronous enable.
module period_meter #(
    parameter logic [13:0] TIMEOUT_CYCLES = 14'd9999
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       sig_in,
    output logic [7:0] Q,
    output logic       valid,
    output logic       ovf,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic        s1_q, s2_q, s3_q;
    logic        rise_s;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [13:0] tcnt_q, tcnt_d;
    logic        sat_q, sat_d;
    logic [7:0]  q_q, q_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;

    // s3 keeps the previous synchronised level so a rise is seen exactly once
    assign rise_s = s2_q & ~s3_q;

    // Synchroniser and edge history; runs independently of en
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Measurement state and output registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            tcnt_q    <= 14'd0;
            sat_q     <= 1'b0;
            q_q       <= 8'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            sat_q     <= sat_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        sat_d     = sat_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        timeout_d = timeout_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            tcnt_d  = 14'd0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = 8'd0;
                    tcnt_d = 14'd0;
                    sat_d  = 1'b0;
                    if (rise_s) begin
                        state_d   = MEASURE;
                        cnt_d     = 8'd1;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MEASURE: begin
                    // A rise in the expiry cycle is checked first so it wins
                    if (rise_s) begin
                        q_d     = cnt_q;
                        ovf_d   = sat_q;
                        valid_d = 1'b1;
                        cnt_d   = 8'd1;
                        tcnt_d  = 14'd0;
                        sat_d   = 1'b0;
                    end else if (tcnt_q == TIMEOUT_CYCLES) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = 8'd0;
                        tcnt_d    = 14'd0;
                        sat_d     = 1'b0;
                    end else begin
                        if (cnt_q == 8'd255) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        tcnt_d = tcnt_q + 14'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    tcnt_d  = 14'd0;
                    sat_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == MEASURE);
    end

    assign Q       = q_q;
    assign valid   = valid_q;
    assign ovf     = ovf_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed table of periods, hand-written
// corner sequences and randomized traffic checked against a timestamp-based model.
module tb_period_meter;

    localparam int TO = 9999;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       sig_in;
    logic [7:0] Q;
    logic       valid;
    logic       ovf;
    logic       timeout;
    logic       busy;

    period_meter dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .sig_in (sig_in),
        .Q      (Q),
        .valid  (valid),
        .ovf    (ovf),
        .timeout(timeout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_m = 0;
    int rq[$];

    // Reference model: timestamps of the acting edges, not counters
    bit m_meas;
    int m_last;
    int m_q;
    bit m_ovf;
    bit m_to;
    bit m_valid;

    typedef struct {
        int period;
        int exp_q;
        bit exp_ovf;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_meas = 1'b0; m_last = 0; m_q = 0; m_ovf = 1'b0; m_to = 1'b0; m_valid = 1'b0;
        rq.delete();
    endtask

    task automatic model_edge();
        bit r;
        int p;
        r = 1'b0;
        while (rq.size() > 0 && rq[0] < cyc) void'(rq.pop_front());
        if (rq.size() > 0 && rq[0] == cyc) begin
            r = 1'b1;
            void'(rq.pop_front());
        end
        if (!en) begin
            m_meas = 1'b0; m_valid = 1'b0;
        end else if (r) begin
            if (m_meas) begin
                p = cyc - m_last;
                m_q = (p > 255) ? 255 : p;
                m_ovf = (p >= 256);
                m_valid = 1'b1;
            end else begin
                m_meas = 1'b1; m_to = 1'b0; m_valid = 1'b0;
            end
            m_last = cyc;
        end else if (m_meas && (cyc - m_last) == TO + 1) begin
            m_meas = 1'b0; m_to = 1'b1; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("model_Q", int'(Q), m_q);
        chk("model_valid", int'(valid), int'(m_valid));
        chk("model_ovf", int'(ovf), int'(m_ovf));
        chk("model_timeout", int'(timeout), int'(m_to));
        chk("model_busy", int'(busy), int'(m_meas));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (clr) model_edge();
        #1;
        compare_model();
        if (sig_in) sig_in = 1'b0;
    endtask

    task automatic advance_to(input int t);
        while (cyc < t) tick();
    endtask

    // A rise driven after edge m acts on the FSM at edge m+3
    task automatic raise();
        sig_in = 1'b1;
        last_m = cyc;
        rq.push_back(cyc + 3);
    endtask

    task automatic pulse(input int p);
        advance_to(last_m + p);
        raise();
    endtask

    task automatic check_rise(input string name, input int eq, input int eovf);
        advance_to(last_m + 3);
        chk({name, "_valid"}, int'(valid), 1);
        chk({name, "_Q"}, int'(Q), eq);
        chk({name, "_ovf"}, int'(ovf), eovf);
        chk({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic check_arm(input string name);
        advance_to(last_m + 3);
        chk({name, "_valid"}, int'(valid), 0);
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic async_reset(input int hold);
        #2 clr = 1'b0;
        #1 model_reset();
        chk("rst_Q", int'(Q), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (hold) tick();
        clr = 1'b1;
        last_m = cyc;
    endtask

    initial begin
        int a;
        int m0;
        int r;
        tbl[0] = '{100, 100, 1'b0};
        tbl[1] = '{100, 100, 1'b0};
        tbl[2] = '{255, 255, 1'b0};
        tbl[3] = '{256, 255, 1'b1};
        tbl[4] = '{300, 255, 1'b1};
        tbl[5] = '{3,   3,   1'b0};

        clr = 1'b0; en = 1'b0; sig_in = 1'b0;
        model_reset();
        #2;
        chk("init_Q", int'(Q), 0);
        chk("init_busy", int'(busy), 0);
        tick(); tick();
        clr = 1'b1; en = 1'b1; last_m = cyc;

        // First edge only arms
        pulse(2);
        check_arm("first_arm");

        foreach (tbl[i]) begin
            pulse(tbl[i].period);
            check_rise($sformatf("tbl%0d", i), tbl[i].exp_q, int'(tbl[i].exp_ovf));
        end

        // Minimum period of two cycles
        pulse(10);
        pulse(2);
        check_rise("p2", 2, 0);

        // Timeout after a Q=50 measurement
        pulse(50);
        check_rise("p50", 50, 0);
        a = last_m + 3;
        advance_to(a + TO);
        chk("pre_to_timeout", int'(timeout), 0);
        chk("pre_to_busy", int'(busy), 1);
        tick();
        chk("to_timeout", int'(timeout), 1);
        chk("to_busy", int'(busy), 0);
        chk("to_Q", int'(Q), 50);
        chk("to_valid", int'(valid), 0);
        pulse(20);
        check_arm("after_to");

        // Edge landing exactly on the expiry cycle wins
        pulse(TO + 1);
        check_rise("expiry_edge", 255, 1);
        chk("expiry_timeout", int'(timeout), 0);

        // Enable dropped for 20 cycles mid-period, edges continue every 40
        pulse(40);
        check_rise("p40", 40, 0);
        m0 = last_m;
        advance_to(m0 + 30);
        en = 1'b0;
        pulse(40);
        advance_to(m0 + 45);
        chk("dis_busy", int'(busy), 0);
        chk("dis_valid", int'(valid), 0);
        advance_to(m0 + 50);
        en = 1'b1;
        pulse(40);
        check_arm("reen_arm");
        pulse(40);
        check_rise("reen_p40", 40, 0);

        // Asynchronous reset mid-period after Q=77
        pulse(77);
        check_rise("p77", 77, 0);
        advance_to(last_m + 30);
        async_reset(3);
        pulse(5);
        check_arm("rst_arm");
        pulse(77);
        check_rise("rst_p77", 77, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                advance_to(cyc + $urandom_range(1, 50));
                async_reset($urandom_range(1, 4));
                pulse($urandom_range(2, 40));
            end else if (r < 4) begin
                advance_to(cyc + $urandom_range(1, 60));
                en = 1'b0;
                advance_to(cyc + $urandom_range(1, 60));
                en = 1'b1;
                pulse($urandom_range(2, 400));
            end else if (r < 7) begin
                pulse($urandom_range(250, 260));
            end else begin
                pulse($urandom_range(2, 400));
            end
        end
        advance_to(cyc + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 14'd9999: clk cycles without a detected edge before measurement is abandoned.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port en, input, 1 bit: measurement enable, synchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1 bit: asynchronous pulse train whose period is measured.
REQ-006 SHALL have port Q, output, 8 bits: last measured period in clk cycles, registered.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when Q is updated.
REQ-008 SHALL have port ovf, output, 1 bit: last measurement saturated (period > 255).
REQ-009 SHALL have port timeout, output, 1 bit: sticky flag, no edge within TIMEOUT_CYCLES.
REQ-010 SHALL have port busy, output, 1 bit: high while in state MEASURE.

Function
REQ-011 SHALL synchronise sig_in through two flip-flops (s1, s2) plus a third history flop s3; rise = s2 & ~s3.
REQ-012 SHALL make rise act on the FSM at the third rising clk edge after sig_in goes high; the latency is fixed and identical for every edge.
REQ-013 SHALL implement two states: IDLE and MEASURE.
REQ-014 IDLE: cnt = 0, tcnt = 0; on rise with en = 1 -> MEASURE, cnt <= 1, tcnt <= 0, timeout <= 0, no valid.
REQ-015 MEASURE, no rise: cnt <= cnt + 1, saturating at 8'd255; tcnt <= tcnt + 1.
REQ-016 MEASURE, rise: Q <= cnt; ovf <= 1 only if cnt saturated before this edge; valid <= 1 for one cycle; cnt <= 1; tcnt <= 0.
REQ-017 Count rule: edges P clk cycles apart SHALL give Q = P for 2 <= P <= 255 with ovf = 0, and Q = 255 with ovf = 1 for P >= 256.
REQ-018 Saturation SHALL be tracked by an internal sat bit: set when cnt increments from 255, cleared on rise.
REQ-019 MEASURE with tcnt == TIMEOUT_CYCLES and no rise -> IDLE, timeout <= 1; Q and ovf hold; no valid.
REQ-020 A rise in the same cycle as timeout expiry SHALL win: a normal measurement per REQ-016, with no timeout.
REQ-021 en = 0 in any state -> IDLE on the next edge: cnt, tcnt and sat cleared; Q, ovf and timeout hold; valid = 0.
REQ-022 The synchroniser SHALL run regardless of en, so no false rise is generated when en returns high.
REQ-023 busy SHALL be 1 exactly while the state is MEASURE.
REQ-024 cnt SHALL be 8 bits and tcnt 14 bits; neither SHALL wrap.

Reset
REQ-025 clr = 0 SHALL immediately force state IDLE, s1 = s2 = s3 = 0, cnt = 0, tcnt = 0, sat = 0, Q = 8'h00, valid = 0, ovf = 0, timeout = 0, busy = 0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; after clr rises, the first rise only arms the block (no valid).
REQ-027 Release of clr SHALL take effect at the next rising clk edge.

Verification
REQ-028 Scenario: reset, en = 1, sig_in rising edges every 100 cycles -> first edge: busy = 1, no valid; each later edge: valid pulse with Q = 100, ovf = 0.
REQ-029 Scenario: edge spacing 255, then 256, then 300 -> Q = 255/ovf = 0, then Q = 255/ovf = 1, then Q = 255/ovf = 1.
REQ-030 Scenario: two edges 50 apart, then no edge for 10000 cycles -> Q = 50 held, timeout = 1 at tcnt = 9999, busy = 0; next edge clears timeout with no valid.
REQ-031 Scenario: en dropped for 20 cycles mid-period, edges every 40 cycles continue -> no valid while disabled; first edge after re-enable only arms; next edge gives Q = 40.
REQ-032 Scenario: clr pulsed low mid-period after Q = 77 -> Q = 0 immediately, all flags 0; the measurement restarts per REQ-026.
REQ-033 Scenario: edge arriving exactly in the timeout-expiry cycle -> valid pulse, Q = 255, ovf = 1, timeout stays 0, busy stays 1.
